// File: rtl/cdb_scheduler.sv
// cdb_scheduler: round-robin arbiter sharing two common data buses (CDB0, CDB1)
// between NUM_REQ result producers. Grants are registered one-cycle pulses.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req             per-producer request (holds a result)
//   i_bus_en          per-bus enable for this cycle's arbitration
//   i_flush           cancels this cycle's arbitration
//   o_grant           one-cycle grant pulse per requester
//   o_bus_sel         per granted requester: 0 = CDB0, 1 = CDB1
//   o_bus_valid       per bus: carries a result this cycle
//   o_bus0_owner      index of CDB0 winner (0 when idle)
//   o_bus1_owner      index of CDB1 winner (0 when idle)
//   o_util_count      saturating count of bus-cycles used
module cdb_scheduler #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_bus_en,
    input  logic               i_flush,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [NUM_REQ-1:0] o_bus_sel,
    output logic [1:0]         o_bus_valid,
    output logic [IDX_W-1:0]   o_bus0_owner,
    output logic [IDX_W-1:0]   o_bus1_owner,
    output logic [15:0]        o_util_count
);

    logic [NUM_REQ-1:0] r_grant, r_bus_sel;
    logic [1:0]         r_bus_valid;
    logic [IDX_W-1:0]   r_bus0_owner, r_bus1_owner, r_ptr;
    logic [15:0]        r_util;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_first_vld, w_second_vld;
    logic [IDX_W-1:0]   w_first_idx, w_second_idx;

    logic [NUM_REQ-1:0] w_grant_d, w_sel_d;
    logic [1:0]         w_valid_d;
    logic [IDX_W-1:0]   w_own0_d, w_own1_d, w_ptr_d;
    logic [16:0]        w_util_sum;
    logic [15:0]        w_util_d;

    // Increment modulo NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] f_wrap_inc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    // Circular scan from r_ptr for the first two eligible requesters.
    // Requesters granted this cycle are masked so a stale request cannot win twice.
    always_comb begin
        int unsigned      pos;
        logic [IDX_W-1:0] v_pos;
        w_elig       = i_req & ~r_grant;
        w_first_vld  = 1'b0;
        w_second_vld = 1'b0;
        w_first_idx  = '0;
        w_second_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = int'(r_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            v_pos = IDX_W'(pos);
            if (w_elig[v_pos]) begin
                if (!w_first_vld) begin
                    w_first_vld = 1'b1;
                    w_first_idx = v_pos;
                end else if (!w_second_vld) begin
                    w_second_vld = 1'b1;
                    w_second_idx = v_pos;
                end
            end
        end
    end

    // Bus assignment: first winner takes the lowest enabled bus, second the other.
    always_comb begin
        w_grant_d = '0;
        w_sel_d   = '0;
        w_valid_d = '0;
        w_own0_d  = '0;
        w_own1_d  = '0;
        w_ptr_d   = r_ptr;
        if (!i_flush && w_first_vld) begin
            unique case (i_bus_en)
                2'b11: begin
                    w_grant_d[w_first_idx] = 1'b1;
                    w_valid_d[0]           = 1'b1;
                    w_own0_d               = w_first_idx;
                    w_ptr_d                = f_wrap_inc(w_first_idx);
                    if (w_second_vld) begin
                        w_grant_d[w_second_idx] = 1'b1;
                        w_sel_d[w_second_idx]   = 1'b1;
                        w_valid_d[1]            = 1'b1;
                        w_own1_d                = w_second_idx;
                        w_ptr_d                 = f_wrap_inc(w_second_idx);
                    end
                end
                2'b01: begin
                    w_grant_d[w_first_idx] = 1'b1;
                    w_valid_d[0]           = 1'b1;
                    w_own0_d               = w_first_idx;
                    w_ptr_d                = f_wrap_inc(w_first_idx);
                end
                2'b10: begin
                    w_grant_d[w_first_idx] = 1'b1;
                    w_sel_d[w_first_idx]   = 1'b1;
                    w_valid_d[1]           = 1'b1;
                    w_own1_d               = w_first_idx;
                    w_ptr_d                = f_wrap_inc(w_first_idx);
                end
                default: begin
                end
            endcase
        end
    end

    // Utilisation accumulates the buses driven in the current cycle, saturating.
    always_comb begin
        w_util_sum = {1'b0, r_util} + 17'(r_bus_valid[0]) + 17'(r_bus_valid[1]);
        w_util_d   = w_util_sum[16] ? 16'hFFFF : w_util_sum[15:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant      <= '0;
            r_bus_sel    <= '0;
            r_bus_valid  <= '0;
            r_bus0_owner <= '0;
            r_bus1_owner <= '0;
            r_ptr        <= '0;
            r_util       <= '0;
        end else begin
            r_grant      <= w_grant_d;
            r_bus_sel    <= w_sel_d;
            r_bus_valid  <= w_valid_d;
            r_bus0_owner <= w_own0_d;
            r_bus1_owner <= w_own1_d;
            r_ptr        <= w_ptr_d;
            r_util       <= w_util_d;
        end
    end

    assign o_grant      = r_grant;
    assign o_bus_sel    = r_bus_sel;
    assign o_bus_valid  = r_bus_valid;
    assign o_bus0_owner = r_bus0_owner;
    assign o_bus1_owner = r_bus1_owner;
    assign o_util_count = r_util;

`ifndef SYNTHESIS
    always @(posedge i_clk) begin
        if (!i_rst) begin
            assert ($countones(r_grant) <= 2)
                else $error("more than two grants");
            assert ($countones(r_grant) == $countones(r_bus_valid))
                else $error("grant count differs from bus count");
            if (r_bus_valid == 2'b11) begin
                assert (r_bus0_owner != r_bus1_owner)
                    else $error("both buses have the same owner");
            end
            if (r_bus_valid[0]) begin
                assert (r_grant[r_bus0_owner]) else $error("bus0 owner not granted");
            end
            if (r_bus_valid[1]) begin
                assert (r_grant[r_bus1_owner]) else $error("bus1 owner not granted");
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_scheduler.sv
// Bench for cdb_scheduler: two instances (NUM_REQ=8 and NUM_REQ=6) driven by the
// same stimulus, each compared every cycle against a queue-based scheduling model,
// plus directed scenarios with literal expectations.
module tb_cdb_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] req = '0;
    logic [1:0] bus_en = 2'b11;

    logic [7:0]  g8, s8;
    logic [1:0]  v8;
    logic [2:0]  o0_8, o1_8;
    logic [15:0] ut8;
    logic [5:0]  g6, s6;
    logic [1:0]  v6;
    logic [2:0]  o0_6, o1_6;
    logic [15:0] ut6;

    cdb_scheduler #(.NUM_REQ(8)) u8 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_bus_en(bus_en), .i_flush(flush),
        .o_grant(g8), .o_bus_sel(s8), .o_bus_valid(v8), .o_bus0_owner(o0_8),
        .o_bus1_owner(o1_8), .o_util_count(ut8)
    );

    cdb_scheduler #(.NUM_REQ(6)) u6 (
        .i_clk(clk), .i_rst(rst), .i_req(req[5:0]), .i_bus_en(bus_en), .i_flush(flush),
        .o_grant(g6), .o_bus_sel(s6), .o_bus_valid(v6), .o_bus0_owner(o0_6),
        .o_bus1_owner(o1_6), .o_util_count(ut6)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model, index 0 = NUM_REQ 8, index 1 = NUM_REQ 6.
    logic [7:0] m_grant[2];
    logic [7:0] m_sel[2];
    logic [1:0] m_valid[2];
    int         m_own0[2];
    int         m_own1[2];
    int         m_ptr[2];
    int         m_util[2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            m_grant[u] = '0; m_sel[u] = '0; m_valid[u] = '0;
            m_own0[u] = 0; m_own1[u] = 0; m_ptr[u] = 0; m_util[u] = 0;
        end
    end

    task automatic model_step(input int u);
        int n;
        int ng;
        int cand[$];
        int buses[$];
        n = (u == 0) ? 8 : 6;
        if (rst) begin
            m_grant[u] = '0; m_sel[u] = '0; m_valid[u] = '0;
            m_own0[u] = 0; m_own1[u] = 0; m_ptr[u] = 0; m_util[u] = 0;
            return;
        end
        m_util[u] = m_util[u] + 32'(m_valid[u][0]) + 32'(m_valid[u][1]);
        if (m_util[u] > 65535) m_util[u] = 65535;
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (m_ptr[u] + k) % n;
            if (req[idx] && !m_grant[u][idx]) cand.push_back(idx);
        end
        m_grant[u] = '0; m_sel[u] = '0; m_valid[u] = '0;
        m_own0[u] = 0; m_own1[u] = 0;
        if (flush) return;
        if (bus_en[0]) buses.push_back(0);
        if (bus_en[1]) buses.push_back(1);
        ng = (cand.size() < buses.size()) ? cand.size() : buses.size();
        for (int j = 0; j < ng; j++) begin
            m_grant[u][cand[j]] = 1'b1;
            m_valid[u][buses[j]] = 1'b1;
            if (buses[j] == 1) begin
                m_sel[u][cand[j]] = 1'b1;
                m_own1[u] = cand[j];
            end else begin
                m_own0[u] = cand[j];
            end
        end
        if (ng > 0) m_ptr[u] = (cand[ng-1] + 1) % n;
    endtask

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) model_step(u);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m8 grant", 32'(g8), 32'(m_grant[0]));
            check("m8 sel", 32'(s8), 32'(m_sel[0]));
            check("m8 valid", 32'(v8), 32'(m_valid[0]));
            check("m8 own0", 32'(o0_8), m_own0[0]);
            check("m8 own1", 32'(o1_8), m_own1[0]);
            check("m8 util", 32'(ut8), m_util[0]);
            check("m6 grant", 32'(g6), 32'(m_grant[1]));
            check("m6 sel", 32'(s6), 32'(m_sel[1]));
            check("m6 valid", 32'(v6), 32'(m_valid[1]));
            check("m6 own0", 32'(o0_6), m_own0[1]);
            check("m6 own1", 32'(o1_6), m_own1[1]);
            check("m6 util", 32'(ut6), m_util[1]);
        end
    end

    // Drive inputs for one edge; on return, outputs reflect that edge.
    task automatic cyc(input logic r, input logic [7:0] q, input logic [1:0] e, input logic f);
        rst = r; req = q; bus_en = e; flush = f;
        @(negedge clk);
    endtask

    initial begin
        cyc(1'b1, 8'h00, 2'b11, 1'b0);
        chk_en = 1'b1;
        cyc(1'b1, 8'h00, 2'b11, 1'b0);
        check("reset grant", 32'(g8), 32'h0);
        check("reset valid", 32'(v8), 32'h0);
        check("reset util", 32'(ut8), 32'h0);

        // Single request from reset
        cyc(1'b0, 8'h08, 2'b11, 1'b0);
        check("t1 grant", 32'(g8), 32'h08);
        check("t1 valid", 32'(v8), 32'h1);
        check("t1 own0", 32'(o0_8), 32'd3);
        check("t1 sel", 32'(s8), 32'h0);
        cyc(1'b0, 8'h00, 2'b11, 1'b0);
        cyc(1'b0, 8'h11, 2'b11, 1'b0);
        check("t1 ptr own0", 32'(o0_8), 32'd4);
        check("t1 ptr own1", 32'(o1_8), 32'd0);

        // Two requests from reset
        cyc(1'b1, 8'h00, 2'b11, 1'b0);
        cyc(1'b0, 8'h21, 2'b11, 1'b0);
        check("t2 grant", 32'(g8), 32'h21);
        check("t2 own0", 32'(o0_8), 32'd0);
        check("t2 own1", 32'(o1_8), 32'd5);
        check("t2 sel", 32'(s8), 32'h20);
        check("t2 valid", 32'(v8), 32'h3);
        cyc(1'b0, 8'h00, 2'b11, 1'b0);
        check("t2 util", 32'(ut8), 32'd2);
        cyc(1'b0, 8'h41, 2'b11, 1'b0);
        check("t2 ptr own0", 32'(o0_8), 32'd6);

        // Held requests with masking
        cyc(1'b1, 8'h00, 2'b11, 1'b0);
        cyc(1'b0, 8'h0E, 2'b11, 1'b0);
        check("t3 c1 grant", 32'(g8), 32'h06);
        cyc(1'b0, 8'h0E, 2'b11, 1'b0);
        check("t3 c2 grant", 32'(g8), 32'h08);
        check("t3 c2 valid", 32'(v8), 32'h1);
        check("t3 c2 own0", 32'(o0_8), 32'd3);
        cyc(1'b0, 8'h0E, 2'b11, 1'b0);
        check("t3 c3 grant", 32'(g8), 32'h06);

        // Wrap-around, NUM_REQ 6 and 8
        cyc(1'b1, 8'h00, 2'b11, 1'b0);
        cyc(1'b0, 8'h10, 2'b11, 1'b0);
        cyc(1'b0, 8'h21, 2'b11, 1'b0);
        check("t4 n6 grant", 32'(g6), 32'h21);
        check("t4 n6 own0", 32'(o0_6), 32'd5);
        check("t4 n6 own1", 32'(o1_6), 32'd0);
        check("t4 n6 sel", 32'(s6), 32'h01);
        cyc(1'b0, 8'h00, 2'b11, 1'b0);
        cyc(1'b0, 8'h40, 2'b11, 1'b0);
        cyc(1'b0, 8'h81, 2'b11, 1'b0);
        check("t4 n8 grant", 32'(g8), 32'h81);
        check("t4 n8 own0", 32'(o0_8), 32'd7);
        check("t4 n8 own1", 32'(o1_8), 32'd0);
        cyc(1'b0, 8'h00, 2'b11, 1'b0);
        cyc(1'b0, 8'h03, 2'b11, 1'b0);
        check("t4 ptr own0", 32'(o0_8), 32'd1);
        check("t4 ptr own1", 32'(o1_8), 32'd0);

        // Bus enables
        cyc(1'b1, 8'h00, 2'b11, 1'b0);
        cyc(1'b0, 8'h03, 2'b10, 1'b0);
        check("t5 grant", 32'(g8), 32'h01);
        check("t5 sel", 32'(s8), 32'h01);
        check("t5 valid", 32'(v8), 32'h2);
        check("t5 own1", 32'(o1_8), 32'd0);
        cyc(1'b0, 8'h03, 2'b00, 1'b0);
        check("t5 no-bus grant", 32'(g8), 32'h0);
        cyc(1'b0, 8'h03, 2'b11, 1'b0);
        check("t5 ptr own0", 32'(o0_8), 32'd1);
        check("t5 ptr own1", 32'(o1_8), 32'd0);

        // Flush and reset during grant
        cyc(1'b0, 8'hFF, 2'b11, 1'b1);
        check("t6 flush grant", 32'(g8), 32'h0);
        check("t6 flush valid", 32'(v8), 32'h0);
        cyc(1'b0, 8'hFF, 2'b11, 1'b0);
        check("t6 post-flush own0", 32'(o0_8), 32'd1);
        check("t6 post-flush own1", 32'(o1_8), 32'd2);
        cyc(1'b1, 8'hFF, 2'b11, 1'b0);
        check("t6 rst grant", 32'(g8), 32'h0);
        check("t6 rst util", 32'(ut8), 32'h0);
        cyc(1'b0, 8'hFF, 2'b11, 1'b0);
        check("t6 post-rst own0", 32'(o0_8), 32'd0);
        check("t6 post-rst own1", 32'(o1_8), 32'd1);

        // Random traffic
        repeat (3000) begin
            cyc($urandom_range(0, 63) == 0, 8'($urandom), 2'($urandom),
                $urandom_range(0, 15) == 0);
        end

        // Utilisation saturation: four requesters keep both buses busy every cycle
        cyc(1'b1, 8'h00, 2'b11, 1'b0);
        repeat (33000) cyc(1'b0, 8'h0F, 2'b11, 1'b0);
        check("sat util n8", 32'(ut8), 32'hFFFF);
        check("sat util n6", 32'(ut6), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
